// File: rtl/seq_muldiv_ctrl_if.sv
// ============================================================================
// seq_muldiv_ctrl_if : request/response bundle for the sequential mul/div unit
// Revision 1.0
// ============================================================================
`default_nettype none

interface seq_muldiv_ctrl_if;
  logic       start;
  logic       op;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/seq_muldiv_ctrl.sv
// ============================================================================
// seq_muldiv_ctrl : 4x4 shift-add multiply / restoring 4/4 divide on one
//                   shared 4-bit ripple adder/subtractor
// Revision 1.0
// ============================================================================
`default_nettype none

module seq_muldiv_ctrl (
  input  wire logic          clk,
  input  wire logic          rst_n,
  seq_muldiv_ctrl_if.slave   mdu
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       op_q, op_d;
  logic [3:0] acc_q, acc_d;     // hi (multiply) or R (divide)
  logic [3:0] shr_q, shr_d;     // lo (multiply) or Q (divide)
  logic [3:0] opnd_q, opnd_d;   // M (multiply) or D (divide)
  logic [1:0] count_q, count_d;
  logic [7:0] result_q, result_d;
  logic       dbz_q, dbz_d;

  logic [3:0] add_a, add_b, add_bx, add_s;
  logic       add_op, add_cout, carry;
  logic [3:0] acc_nx, shr_nx;

  // Shared ripple adder/subtractor: Op=1 computes A + ~B + 1, Cout=1 means no borrow
  assign add_op = op_q;
  assign add_a  = op_q ? {acc_q[2:0], shr_q[3]} : acc_q;
  assign add_b  = opnd_q;
  assign add_bx = add_b ^ {4{add_op}};

  always_comb begin
    carry = add_op;
    add_s = 4'h0;
    for (int i = 0; i < 4; i++) begin
      add_s[i] = add_a[i] ^ add_bx[i] ^ carry;
      carry    = (add_a[i] & add_bx[i]) | (carry & (add_a[i] ^ add_bx[i]));
    end
    add_cout = carry;
  end

  always_comb begin
    acc_nx = acc_q;
    shr_nx = shr_q;
    if (op_q) begin
      // acc_q[3] set means the shifted remainder is >= 16 > D, so S is valid mod 16
      if (acc_q[3] || add_cout) begin
        acc_nx = add_s;
        shr_nx = {shr_q[2:0], 1'b1};
      end else begin
        acc_nx = {acc_q[2:0], shr_q[3]};
        shr_nx = {shr_q[2:0], 1'b0};
      end
    end else begin
      if (shr_q[0]) begin
        acc_nx = {add_cout, add_s[3:1]};
        shr_nx = {add_s[0], shr_q[3:1]};
      end else begin
        acc_nx = {1'b0, acc_q[3:1]};
        shr_nx = {acc_q[0], shr_q[3:1]};
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    shr_d    = shr_q;
    opnd_d   = opnd_q;
    count_d  = count_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (mdu.start) begin
          op_d    = mdu.op;
          acc_d   = 4'h0;
          shr_d   = mdu.op ? mdu.a : mdu.b;
          opnd_d  = mdu.op ? mdu.b : mdu.a;
          count_d = 2'd0;
          dbz_d   = 1'b0;
          if (mdu.op && (mdu.b == 4'h0)) begin
            state_d  = S_DONE;
            result_d = {mdu.a, 4'hF};
            dbz_d    = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d   = acc_nx;
        shr_d   = shr_nx;
        count_d = count_q + 2'd1;
        if (count_q == 2'd3) begin
          state_d  = S_DONE;
          result_d = {acc_nx, shr_nx};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      acc_q    <= 4'h0;
      shr_q    <= 4'h0;
      opnd_q   <= 4'h0;
      count_q  <= 2'd0;
      result_q <= 8'h00;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      shr_q    <= shr_d;
      opnd_q   <= opnd_d;
      count_q  <= count_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign mdu.busy        = (state_q != S_IDLE);
  assign mdu.done        = (state_q == S_DONE);
  assign mdu.result      = result_q;
  assign mdu.div_by_zero = dbz_q;

endmodule

`default_nettype wire
